// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 receive path: FSM states and the received frame payload.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  typedef struct packed {
    logic [PS2_DATA_BITS-1:0] data;
    logic                     parity;
  } ps2_frame_t;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic parity_ok(input ps2_frame_t f);
    return ^{f.data, f.parity};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok_c;
  logic             rd_ok_c;
  logic [CW-1:0]    count_nxt_c;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  always_comb begin
    wr_ok_c     = wr_en && (!full || rd_en);
    rd_ok_c     = rd_en && !empty;
    count_nxt_c = count + CW'(wr_ok_c) - CW'(rd_ok_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  // Head is forced to zero while empty so stale entries never leak out.
  assign rd_data_c = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisation, clock deglitch, frame decode,
// stall timeout and a scancode FIFO with a valid/ready pop interface.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [PS2_DATA_BITS-1:0]      o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  input  logic                          i_clr_err
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W          = $clog2(PS2_DATA_BITS);

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_nxt_c;
  logic                  filt;
  logic                  filt_d;
  logic                  fall_stb;
  logic                  dat_s;

  ps2_state_e            state, state_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  ps2_frame_t            frame, frame_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic                  tmo_hit_c;
  logic                  push_c;
  logic                  perr_nxt;
  logic                  ferr_nxt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  ovf_set_c;

  assign dat_s      = dat_sync[1];
  assign hist_nxt_c = {hist[FILTER_LEN-2:0], clk_sync[1]};

  // Synchronise both pins; the clock then needs FILTER_LEN equal samples to change level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      hist     <= '1;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      fall_stb <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      hist     <= hist_nxt_c;
      if (&hist_nxt_c)       filt <= 1'b1;
      else if (~|hist_nxt_c) filt <= 1'b0;
      filt_d   <= filt;
      fall_stb <= filt_d & ~filt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      frame        <= '0;
      tmo_cnt      <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      frame        <= frame_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      o_parity_err <= perr_nxt;
      o_frame_err  <= ferr_nxt;
    end
  end

  // Frame decode; a stall inside a frame takes priority over any coincident edge.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    frame_nxt   = frame;
    tmo_cnt_nxt = tmo_cnt;
    push_c      = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    tmo_hit_c   = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    if (state == IDLE || fall_stb) tmo_cnt_nxt = '0;
    else if (!tmo_hit_c)           tmo_cnt_nxt = tmo_cnt + TMO_W'(1);

    if (tmo_hit_c) begin
      state_nxt = IDLE;
      frame_nxt = '0;
      ferr_nxt  = 1'b1;
    end else if (fall_stb) begin
      unique case (state)
        IDLE: begin
          if (!dat_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          frame_nxt.data[bit_cnt] = dat_s;
          bit_cnt_nxt             = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(PS2_DATA_BITS - 1)) state_nxt = PARITY;
        end
        PARITY: begin
          frame_nxt.parity = dat_s;
          state_nxt        = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          perr_nxt  = !parity_ok(frame);
          ferr_nxt  = !dat_s;
          push_c    = dat_s && parity_ok(frame);
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (push_c),
    .wr_data   (frame.data),
    .rd_en     (i_ready),
    .rd_data_c (o_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  assign o_valid   = ~fifo_empty;
  assign ovf_set_c = push_c && fifo_full && !(i_ready && o_valid);

  // Sticky overflow; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          o_overflow <= 1'b0;
    else if (ovf_set_c) o_overflow <= 1'b1;
    else if (i_clr_err) o_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed frame table, corner sequences and
// randomized frames against a queue-based reference model.
module tb_ps2_rx_fifo;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned TMO_US  = 100;
  localparam int unsigned FLEN    = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TMO_CYC = CLK_HZ / 1_000_000 * TMO_US;
  localparam int          HP      = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       i_ready = 1'b0;
  logic       i_clr_err = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic [3:0] o_count;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_overflow;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TIMEOUT_US  (TMO_US),
    .FILTER_LEN  (FLEN),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overflow   (o_overflow),
    .i_clr_err    (i_clr_err)
  );

  int  n_tests = 0;
  int  n_fail = 0;
  int  perr_seen = 0;
  int  ferr_seen = 0;
  longint last_ferr_t = 0;

  always @(negedge clk) begin
    if (o_parity_err) perr_seen++;
    if (o_frame_err) begin
      ferr_seen++;
      last_ferr_t = $time;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Device-side frame driver; optional clock glitch and a pop timed onto the push cycle.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit,
                           input bit pop_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        cyc_wait(3);
        ps2_clk = 1'b0;
        cyc_wait(2);
        ps2_clk = 1'b1;
        cyc_wait(HP - 5);
      end else begin
        cyc_wait(HP);
      end
      ps2_clk = 1'b0;
      if (pop_stop && i == 10) begin
        cyc_wait(7);
        i_ready = 1'b1;
        cyc_wait(1);
        i_ready = 1'b0;
        cyc_wait(HP - 8);
      end else begin
        cyc_wait(HP);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc_wait(HP);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bits(mk_frame(d, par, stop), 11, -1, 1'b0);
    cyc_wait(4);
  endtask

  task automatic pop();
    i_ready = 1'b1;
    cyc_wait(1);
    i_ready = 1'b0;
  endtask

  task automatic clr_err();
    i_clr_err = 1'b1;
    cyc_wait(1);
    i_clr_err = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       exp_push;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] q[$];
  logic       ovf_m;
  int         p0, f0, gap;
  longint     t_fall;
  logic [7:0] d;
  logic       bad_par, bad_stop;
  int         npop;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hA7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    cyc_wait(3);
    chk("reset_outputs", 32'({o_data, o_valid, o_count, o_parity_err, o_frame_err, o_overflow}), 32'h0);
    rstn = 1'b1;
    cyc_wait(5);
    chk("post_reset_outputs", 32'({o_data, o_valid, o_count, o_parity_err, o_frame_err, o_overflow}), 32'h0);

    // Directed frame table
    for (int i = 0; i < 7; i++) begin
      p0 = perr_seen;
      f0 = ferr_seen;
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop);
      chk($sformatf("tbl%0d_perr", i), 32'(perr_seen - p0), 32'(vecs[i].exp_perr));
      chk($sformatf("tbl%0d_ferr", i), 32'(ferr_seen - f0), 32'(vecs[i].exp_ferr));
      chk($sformatf("tbl%0d_count", i), 32'(o_count), 32'(vecs[i].exp_push));
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_push));
      if (vecs[i].exp_push) begin
        chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(vecs[i].d));
        pop();
        chk($sformatf("tbl%0d_popped", i), 32'(o_valid), 32'h0);
      end
    end

    // Overflow: nine good frames with no pops
    for (int i = 1; i <= 9; i++) send_frame(8'(i), ~^8'(i), 1'b1);
    chk("ovf_count", 32'(o_count), 32'd8);
    chk("ovf_flag", 32'(o_overflow), 32'h1);
    chk("ovf_head", 32'(o_data), 32'h01);
    clr_err();
    chk("ovf_cleared", 32'(o_overflow), 32'h0);

    // Push and pop in the same cycle while full
    send_bits(mk_frame(8'h0A, ~^8'h0A, 1'b1), 11, -1, 1'b1);
    cyc_wait(4);
    chk("full_pushpop_count", 32'(o_count), 32'd8);
    chk("full_pushpop_ovf", 32'(o_overflow), 32'h0);
    q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(o_data), 32'(q[i]));
      pop();
    end
    q.delete();
    chk("drain_empty", 32'(o_valid), 32'h0);

    // Push and pop in the same cycle while empty: push only
    send_bits(mk_frame(8'h3C, ~^8'h3C, 1'b1), 11, -1, 1'b1);
    cyc_wait(4);
    chk("empty_pushpop_count", 32'(o_count), 32'd1);
    chk("empty_pushpop_data", 32'(o_data), 32'h3C);
    pop();

    // Timeout after start plus five data bits
    p0 = perr_seen;
    f0 = ferr_seen;
    send_bits(mk_frame(8'hA5, 1'b1, 1'b1), 6, -1, 1'b0);
    t_fall = $time - longint'(2 * HP * 10);
    for (int k = 0; k < 300 && ferr_seen == f0; k++) @(posedge clk);
    cyc_wait(1);
    chk("tmo_ferr_pulses", 32'(ferr_seen - f0), 32'd1);
    gap = int'((last_ferr_t - t_fall) / 10);
    chk("tmo_window", 32'(gap >= int'(TMO_CYC) && gap <= int'(TMO_CYC + FLEN + 8)), 32'h1);
    chk("tmo_no_push", 32'(o_count), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("tmo_next_count", 32'(o_count), 32'd1);
    chk("tmo_next_data", 32'(o_data), 32'h5A);
    chk("tmo_no_perr", 32'(perr_seen - p0), 32'd0);
    pop();

    // Clock glitch mid-frame must not consume a bit
    p0 = perr_seen;
    f0 = ferr_seen;
    send_bits(mk_frame(8'h33, ~^8'h33, 1'b1), 11, 5, 1'b0);
    cyc_wait(4);
    chk("glitch_count", 32'(o_count), 32'd1);
    chk("glitch_data", 32'(o_data), 32'h33);
    chk("glitch_errs", 32'((perr_seen - p0) + (ferr_seen - f0)), 32'd0);
    pop();

    // Reset in the middle of a frame with two bytes queued
    send_frame(8'h11, ~^8'h11, 1'b1);
    send_frame(8'h22, ~^8'h22, 1'b1);
    chk("mid_rst_queued", 32'(o_count), 32'd2);
    send_bits(mk_frame(8'h77, ~^8'h77, 1'b1), 5, -1, 1'b0);
    rstn = 1'b0;
    cyc_wait(2);
    chk("mid_rst_outputs", 32'({o_data, o_valid, o_count, o_parity_err, o_frame_err, o_overflow}), 32'h0);
    rstn = 1'b1;
    cyc_wait(3);
    f0 = ferr_seen;
    send_frame(8'h29, 1'b0, 1'b1);
    chk("after_rst_count", 32'(o_count), 32'd1);
    chk("after_rst_data", 32'(o_data), 32'h29);
    chk("after_rst_ferr", 32'(ferr_seen - f0), 32'd0);
    pop();

    // Randomized frames against the queue model
    ovf_m = 1'b0;
    for (int n = 0; n < 40; n++) begin
      d        = 8'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 5) == 0);
      p0 = perr_seen;
      f0 = ferr_seen;
      send_frame(d, (~^d) ^ bad_par, ~bad_stop);
      if (!bad_par && !bad_stop) begin
        if (q.size() < DEPTH) q.push_back(d);
        else                  ovf_m = 1'b1;
      end
      chk($sformatf("rnd%0d_perr", n), 32'(perr_seen - p0), 32'(bad_par));
      chk($sformatf("rnd%0d_ferr", n), 32'(ferr_seen - f0), 32'(bad_stop));
      chk($sformatf("rnd%0d_count", n), 32'(o_count), 32'(q.size()));
      chk($sformatf("rnd%0d_ovf", n), 32'(o_overflow), 32'(ovf_m));
      if (q.size() > 0) chk($sformatf("rnd%0d_head", n), 32'(o_data), 32'(q[0]));
      npop = (n < 20) ? 0 : int'($urandom_range(0, 3));
      for (int k = 0; k < npop; k++) begin
        if (q.size() > 0) begin
          chk($sformatf("rnd%0d_pop%0d", n, k), 32'(o_data), 32'(q[0]));
          void'(q.pop_front());
        end
        pop();
      end
      if ($urandom_range(0, 4) == 0) begin
        clr_err();
        ovf_m = 1'b0;
      end
    end
    chk("rnd_final_count", 32'(o_count), 32'(q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 keyboard receive front-end between the board PS2_CLK/PS2_DATA pins and the SoC keyboard peripheral register interface inside the core.
- Synchronises and deglitches the device-driven PS/2 clock, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Checks each frame, times out stalled frames, and buffers good scancodes in a small FIFO with a valid/ready pop interface for the CPU-side register block.
- Receive-only; never drives the PS/2 lines.

Parameters:
- CLK_FREQ_HZ, 50_000_000, core clock frequency; sets the timeout.
- TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside a frame. TIMEOUT_CYCLES = CLK_FREQ_HZ/1_000_000*TIMEOUT_US.
- FILTER_LEN, 4, consecutive equal samples needed before the filtered PS/2 clock changes level.
- FIFO_DEPTH, 8, scancode entries; power of two, at least 2.

Ports:
- clk  in  1  core clock (clk_core domain).
- rstn  in  1  reset, asynchronous assert, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- o_data  out  8  scancode at FIFO head.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  pop request; pops when o_valid && i_ready.
- o_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_parity_err  out  1  one-cycle pulse on a parity failure.
- o_frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout.
- o_overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full.
- i_clr_err  in  1  clears o_overflow.

Behaviour:
- Reset (rstn low, asynchronous) clears:
  - all outputs to 0;
  - FIFO pointers and occupancy;
  - FSM to IDLE;
  - synchroniser and filter state to 1 (idle line level).
- Input path:
  - Both pins pass through a 2-FF synchroniser.
  - ps2_clk additionally passes through a FILTER_LEN-sample filter; the filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge of the filtered clock raises a registered one-cycle fall_stb. Synchronised data is sampled in the same cycle.
- FSM (package enum) states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_stb with data=0 go to DATA, bit_cnt=0. With data=1 stay in IDLE; no error is raised.
  - DATA: on fall_stb shift data into shreg[bit_cnt]. After bit 7 go to PARITY.
  - PARITY: on fall_stb store the bit, then go to STOP.
  - STOP: on fall_stb go to IDLE. The result depends on the received bits:
    - data=1 and ^{shreg,par}==1: push the byte.
    - Parity wrong: pulse o_parity_err, no push.
    - Stop bit 0: pulse o_frame_err, no push.
    - Both wrong: pulse both.
- Timeout:
  - A counter reloads on every fall_stb and counts while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, pulse o_frame_err, discard the partial byte.
- Latency: the pushed byte appears on o_data with o_valid=1 in the cycle after the fall_stb of the stop bit. From the raw pin edge this is 2 + FILTER_LEN + 2 cycles.
- FIFO:
  - First-word fall-through; o_data is valid whenever o_valid=1.
  - o_count is the registered occupancy.
  - Push when full and no pop: byte dropped, o_overflow set.
  - Push and pop in the same cycle when full: both occur, count stays at FIFO_DEPTH, no overflow.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag: i_clr_err clears o_overflow. If i_clr_err and a new overflow occur in the same cycle, the set wins.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - PS2_DATA_BITS=8;
  - the ps2_frame_t struct {data, parity}.
- Sub-module sync_fifo: parameterised width and depth, FWFT, with full, empty and count outputs. Instantiated once with width 8.
- The FSM, filter and timeout counter live in ps2_rx_fifo.

Test Plan:
- Good frame: send 0x1C with parity bit 0 and stop bit 1 at 12.5 kHz → o_valid=1, o_data=0x1C, o_count=1, no error pulses. Pulse i_ready → o_valid=0.
- Bad parity: send 0x1C with parity bit 1 → exactly one o_parity_err pulse, o_count stays 0. A following good frame 0xF0 (parity 1) is then received correctly.
- Overflow: send 9 good frames 0x01..0x09 with i_ready=0 → o_count=8, o_overflow=1, o_data=0x01. Pop all → order 0x01..0x08. i_clr_err → o_overflow=0.
- Timeout: send start plus 5 data bits, then hold the lines idle → o_frame_err pulses TIMEOUT_CYCLES after the last edge, FSM returns to IDLE. The next frame 0x5A is accepted.
- Glitch rejection: inject a 2-cycle low pulse on ps2_clk mid-frame (FILTER_LEN=4) → no bit is consumed and the frame decodes correctly.
- Reset mid-frame: assert rstn low after bit 3 with 2 bytes queued → all outputs 0, FIFO empty. After release, a fresh frame 0x29 is received alone.
